ps2_teclado_rx: RTL

- Upstream stage of the keyboard path: receives PS/2 device-to-host frames and produces the 8-bit `dato_teclado` byte consumed by the PicoBlaze input mux.
- Synchronises and filters the PS/2 clock/data lines, deserialises 11-bit frames and checks them.
- Decodes make, break (F0) and extended (E0) prefixes, so the CPU polls a stable "key currently held" code instead of raw scan bytes.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_teclado_rx_if.sv | 17 +
 rtl/ps2_filtro_flanco.sv | 47 ++++
 rtl/ps2_teclado_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared encodings and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  typedef logic [1:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE   = 2'd0;
  localparam ps2_state_t ST_DATA   = 2'd1;
  localparam ps2_state_t ST_PARITY = 2'd2;
  localparam ps2_state_t ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  // PS/2 uses odd parity: the 8 data bits plus parity must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_teclado_rx_if.sv
// Result bus of the PS/2 receiver towards the PicoBlaze input mux.
interface ps2_teclado_rx_if;
  logic [7:0] dato_teclado;
  logic       tecla_ext;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       err_parity;
  logic       err_frame;

  modport master (
    output dato_teclado, tecla_ext, rx_byte, rx_done, err_parity, err_frame
  );

  modport slave (
    input dato_teclado, tecla_ext, rx_byte, rx_done, err_parity, err_frame
  );
endinterface

// File: rtl/ps2_filtro_flanco.sv
// Synchronises both PS/2 lines, glitch-filters the clock and flags each
// filtered falling edge with a one-cycle pulse.
module ps2_filtro_flanco #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_ff;
  logic [1:0]    data_ff;
  logic          clk_filt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_ff   <= '1;
      data_ff  <= '1;
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_ff  <= {clk_ff[0], ps2_clk};
      data_ff <= {data_ff[0], ps2_data};
      fall    <= 1'b0;
      // Counts consecutive samples disagreeing with the filtered level; any agreeing sample restarts it.
      if (clk_ff[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_ff[1];
        cnt      <= '0;
        fall     <= clk_filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_sync = data_ff[1];

endmodule

// File: rtl/ps2_teclado_rx.sv
// PS/2 device-to-host receiver: frame deserialiser, checks and make/break/E0
// decoding into a stable "key currently held" code.
module ps2_teclado_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_teclado_rx_if.master    rx_if
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall;
  logic          data_sync;

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt;

  logic [7:0]    dato_q;
  logic          ext_q;
  logic [7:0]    rx_byte_q;
  logic          rx_done_q;
  logic          err_parity_q;
  logic          err_frame_q;
  logic          pend_brk;
  logic          pend_ext;

  ps2_filtro_flanco #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filtro (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall      (fall),
    .data_sync (data_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt       <= '0;
      dato_q       <= '0;
      ext_q        <= 1'b0;
      rx_byte_q    <= '0;
      rx_done_q    <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      pend_brk     <= 1'b0;
      pend_ext     <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;

      // A fall takes priority over an expiring timeout in the same cycle.
      if (fall) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              err_frame_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q <= {data_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q <= data_sync;
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!data_sync) begin
              err_frame_q <= 1'b1;
            end else if (!odd_parity_ok(shift_q, par_q)) begin
              err_parity_q <= 1'b1;
            end else begin
              rx_byte_q <= shift_q;
              rx_done_q <= 1'b1;
              if (shift_q == PS2_PREFIX_EXT) begin
                pend_ext <= 1'b1;
              end else if (shift_q == PS2_PREFIX_BRK) begin
                pend_brk <= 1'b1;
              end else begin
                if (!pend_brk) begin
                  dato_q <= shift_q;
                  ext_q  <= pend_ext;
                end else if (shift_q == dato_q && pend_ext == ext_q) begin
                  dato_q <= '0;
                  ext_q  <= 1'b0;
                end
                pend_brk <= 1'b0;
                pend_ext <= 1'b0;
              end
            end
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state       <= ST_IDLE;
          to_cnt      <= '0;
          err_frame_q <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  assign rx_if.dato_teclado = dato_q;
  assign rx_if.tecla_ext    = ext_q;
  assign rx_if.rx_byte      = rx_byte_q;
  assign rx_if.rx_done      = rx_done_q;
  assign rx_if.err_parity   = err_parity_q;
  assign rx_if.err_frame    = err_frame_q;

endmodule
